// File: rtl/mac_acc_engine.sv
// -----------------------------------------------------------------------------
// mac_acc_engine
//
// Purpose:
//   Dot-product accumulator in the PE clock domain. Incoming 256-bit words
//   (LANES signed DW-bit operand pairs each) are buffered in a small FIFO,
//   because the upstream stage cannot be stalled. A job started with a length
//   pops that many words, multiplies each operand pair, sums the lane products
//   and accumulates them. One signed ACC_W-bit result per job is presented
//   through a valid/ready handshake.
//
// Ports:
//   clk_pe          in   PE clock, the only clock of the block
//   rst_n           in   asynchronous, active-low reset
//   data_valid_i    in   input word valid, one cycle per word
//   data_i          in   input word; lane k: a = [16k+7:16k], b = [16k+15:16k+8]
//   start_i         in   job start request (honoured only when idle)
//   cfg_len_i       in   number of words in the job, sampled on start
//   result_valid_o  out  job result available
//   result_o        out  accumulated signed dot product (wraps modulo 2^ACC_W)
//   result_ready_i  in   consumer accepts the result
//   busy_o          out  engine is not idle
//   fifo_full_o     out  FIFO holds FIFO_DEPTH entries
//   overflow_o      out  sticky: a word was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module mac_acc_engine #(
    parameter int LANES      = 16,
    parameter int DW         = 8,
    parameter int ACC_W      = 32,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk_pe,
    input  logic                     rst_n,
    input  logic                     data_valid_i,
    input  logic [LANES*2*DW-1:0]    data_i,
    input  logic                     start_i,
    input  logic [LEN_W-1:0]         cfg_len_i,
    output logic                     result_valid_o,
    output logic [ACC_W-1:0]         result_o,
    input  logic                     result_ready_i,
    output logic                     busy_o,
    output logic                     fifo_full_o,
    output logic                     overflow_o
);

    localparam int DATA_W = LANES * 2 * DW;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int PROD_W = 2 * DW;
    localparam int SUM_W  = PROD_W + $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and pointers; pointers carry one extra wrap bit so that
    // full and empty can be told apart without a separate counter.
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full;
    logic              pop, push, drop;
    logic [DATA_W-1:0] head;

    // Job bookkeeping
    logic [LEN_W-1:0]  len_q, cnt_q;
    logic              start_acc;
    logic              last_pop;
    logic              ovf_q;

    // Datapath pipeline
    logic signed [PROD_W-1:0] op_a [LANES];
    logic signed [PROD_W-1:0] op_b [LANES];
    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic                     s1_valid_q;
    logic signed [SUM_W-1:0]  lane_sum;
    logic [ACC_W-1:0]         acc_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];

    // A word is consumed every RUN cycle that finds data waiting. A push is
    // only refused when the FIFO is full and nothing leaves it this cycle.
    assign pop       = (state_q == RUN) && !fifo_empty;
    assign push      = data_valid_i && (!fifo_full || pop);
    assign drop      = data_valid_i && fifo_full && !pop;
    assign start_acc = (state_q == IDLE) && start_i;
    assign last_pop  = pop && ((cnt_q + LEN_W'(1)) == len_q);

    // FIFO word storage; the contents need no reset because the pointers
    // decide what is valid.
    always_ff @(posedge clk_pe) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk_pe or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as a start still sets it, so
    // the new job never hides a word lost at its own start.
    always_ff @(posedge clk_pe or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (start_acc) begin
            ovf_q <= 1'b0;
        end
    end

    // Job length is latched at start; the word counter counts pops.
    always_ff @(posedge clk_pe or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (start_acc) begin
            len_q <= cfg_len_i;
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + LEN_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk_pe or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The last word's product is registered on the pop
    // edge and accumulated on the following (DRAIN) edge, so a single DRAIN
    // cycle lets the two pipeline edges complete before DONE shows the sum.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (cfg_len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_pop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage 1 products: operands are sign-extended to the product width first
    // so the multiply is done entirely at full signed width.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            op_a[k]   = {{DW{head[k*2*DW+DW-1]}},   head[k*2*DW +: DW]};
            op_b[k]   = {{DW{head[k*2*DW+2*DW-1]}}, head[k*2*DW+DW +: DW]};
            prod_d[k] = op_a[k] * op_b[k];
        end
    end

    // Stage 1 register, captured on the edge that pops the word
    always_ff @(posedge clk_pe or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            s1_valid_q <= pop;
            if (pop) begin
                for (int k = 0; k < LANES; k++) begin
                    prod_q[k] <= prod_d[k];
                end
            end
        end
    end

    // Stage 2 adder tree; the sum width leaves room for LANES full-scale
    // products without losing the sign.
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum +
                       {{(SUM_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]};
        end
    end

    // Accumulator: cleared on start, wraps naturally on overflow
    always_ff @(posedge clk_pe or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (start_acc) begin
            acc_q <= '0;
        end else if (s1_valid_q) begin
            acc_q <= acc_q + {{(ACC_W-SUM_W){lane_sum[SUM_W-1]}}, lane_sum};
        end
    end

    assign result_valid_o = (state_q == DONE);
    assign result_o       = acc_q;
    assign busy_o         = (state_q != IDLE);
    assign fifo_full_o    = fifo_full;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_mac_acc_engine.sv
// -----------------------------------------------------------------------------
// tb_mac_acc_engine
//
// Directed bench for mac_acc_engine. A behavioural model (word queue plus the
// job phase and a plain-integer dot product) predicts every output; a compare
// process checks the DUT against it on each falling edge. Hand-computed
// literals in the stimulus pin the model itself.
// -----------------------------------------------------------------------------
module tb_mac_acc_engine;

    logic          clkPe;
    logic          rstN;
    logic          dataValid;
    logic [255:0]  dataIn;
    logic          startReq;
    logic [7:0]    cfgLen;
    logic          resultValid;
    logic [31:0]   resultOut;
    logic          resultReady;
    logic          busy;
    logic          fifoFull;
    logic          overflow;

    int nChecks = 0;
    int nFails  = 0;

    mac_acc_engine dut (
        .clk_pe         (clkPe),
        .rst_n          (rstN),
        .data_valid_i   (dataValid),
        .data_i         (dataIn),
        .start_i        (startReq),
        .cfg_len_i      (cfgLen),
        .result_valid_o (resultValid),
        .result_o       (resultOut),
        .result_ready_i (resultReady),
        .busy_o         (busy),
        .fifo_full_o    (fifoFull),
        .overflow_o     (overflow)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25 ...
    initial clkPe = 1'b0;
    always #5 clkPe = ~clkPe;

    // One comparison: counted always, reported only on disagreement
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Builds a word with every lane carrying the same operand pair
    function automatic logic [255:0] mkWord(input logic [7:0] a, input logic [7:0] b);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            w[16*k +: 8]   = a;
            w[16*k+8 +: 8] = b;
        end
        return w;
    endfunction

    // Signed dot product of one word, in plain integer arithmetic
    function automatic logic [31:0] dotWord(input logic [255:0] w);
        int s;
        s = 0;
        for (int k = 0; k < 16; k++) begin
            s += int'($signed(w[16*k +: 8])) * int'($signed(w[16*k+8 +: 8]));
        end
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: words queue up, a job consumes them one per cycle,
    // the result appears two cycles after the last word is taken.
    // ------------------------------------------------------------------
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mPhase_t;
    mPhase_t       mPhase;
    logic [255:0]  mq[$];
    logic [255:0]  mWord;
    logic [31:0]   mRes;
    bit            mOvf;
    int            mLen;
    int            mCnt;

    always @(posedge clkPe) begin
        if (!rstN) begin
            mq.delete();
            mPhase = M_IDLE;
            mRes   = '0;
            mOvf   = 1'b0;
            mLen   = 0;
            mCnt   = 0;
        end else begin
            case (mPhase)
                M_IDLE: begin
                    if (startReq) begin
                        mLen   = int'(cfgLen);
                        mCnt   = 0;
                        mRes   = '0;
                        mOvf   = 1'b0;
                        mPhase = (mLen == 0) ? M_DONE : M_RUN;
                    end
                end
                M_RUN: begin
                    if (mq.size() > 0) begin
                        mWord = mq.pop_front();
                        mRes  = mRes + dotWord(mWord);
                        mCnt++;
                        if (mCnt == mLen) mPhase = M_DRAIN;
                    end
                end
                M_DRAIN: mPhase = M_DONE;
                M_DONE: begin
                    if (resultReady) mPhase = M_IDLE;
                end
            endcase
            if (dataValid) begin
                if (mq.size() < 4) mq.push_back(dataIn);
                else mOvf = 1'b1;
            end
        end
    end

    // Compare process: every falling edge, DUT against the model
    always @(negedge clkPe) begin
        if (!rstN) begin
            checkOutput("rstValid", {31'd0, resultValid}, 32'd0);
            checkOutput("rstResult", resultOut, 32'd0);
            checkOutput("rstBusy", {31'd0, busy}, 32'd0);
            checkOutput("rstFull", {31'd0, fifoFull}, 32'd0);
            checkOutput("rstOvf", {31'd0, overflow}, 32'd0);
        end else begin
            checkOutput("cmpValid", {31'd0, resultValid}, {31'd0, mPhase == M_DONE});
            checkOutput("cmpBusy", {31'd0, busy}, {31'd0, mPhase != M_IDLE});
            checkOutput("cmpFull", {31'd0, fifoFull}, {31'd0, mq.size() == 4});
            checkOutput("cmpOvf", {31'd0, overflow}, {31'd0, mOvf});
            if (mPhase == M_DONE) checkOutput("cmpResult", resultOut, mRes);
        end
    end

    // One input cycle: drive the given inputs, hold them over one rising edge
    task automatic applyStimulus(input logic valid, input logic [255:0] word,
                                 input logic start, input logic [7:0] len,
                                 input logic ready);
        dataValid   = valid;
        dataIn      = word;
        startReq    = start;
        cfgLen      = len;
        resultReady = ready;
        @(negedge clkPe);
        dataValid   = 1'b0;
        startReq    = 1'b0;
        resultReady = 1'b0;
    endtask

    task automatic pushWord(input logic [255:0] w);
        applyStimulus(1'b1, w, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic startJob(input logic [7:0] len);
        applyStimulus(1'b0, '0, 1'b1, len, 1'b0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 8'd0, 1'b0);
    endtask

    // Waits (bounded) for result_valid_o, returning the cycles waited
    task automatic waitValid(output int cycles);
        cycles = 0;
        while (!resultValid && cycles < 50) begin
            @(negedge clkPe);
            cycles++;
        end
        if (!resultValid) checkOutput("validTimeout", 32'd0, 32'd1);
    endtask

    task automatic handshake();
        applyStimulus(1'b0, '0, 1'b0, 8'd0, 1'b1);
    endtask

    int lat;

    initial begin
        rstN        = 1'b0;
        dataValid   = 1'b0;
        dataIn      = '0;
        startReq    = 1'b0;
        cfgLen      = '0;
        resultReady = 1'b0;

        #3;
        checkOutput("resetValid", {31'd0, resultValid}, 32'd0);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetResult", resultOut, 32'd0);
        @(negedge clkPe);
        @(negedge clkPe);
        #2 rstN = 1'b1;
        @(negedge clkPe);

        // len=1, a=1 b=2 in every lane: 16*2 = 32
        $display("[TB] test 1: single word job");
        pushWord(mkWord(8'd1, 8'd2));
        startJob(8'd1);
        checkOutput("t1Busy", {31'd0, busy}, 32'd1);
        waitValid(lat);
        checkOutput("t1Latency", lat, 32'd2);
        checkOutput("t1Result", resultOut, 32'h0000_0020);
        checkOutput("t1BusyDone", {31'd0, busy}, 32'd1);
        handshake();
        checkOutput("t1ValidDrop", {31'd0, resultValid}, 32'd0);
        checkOutput("t1Idle", {31'd0, busy}, 32'd0);

        // len=3, a=-1 b=127 with gaps 0, 2, 5: 3*16*(-127) = -6096
        $display("[TB] test 2: stalled three word job");
        startJob(8'd3);
        pushWord(mkWord(8'hFF, 8'h7F));
        idleCycles(2);
        pushWord(mkWord(8'hFF, 8'h7F));
        idleCycles(5);
        pushWord(mkWord(8'hFF, 8'h7F));
        waitValid(lat);
        checkOutput("t2Latency", lat, 32'd2);
        checkOutput("t2Result", resultOut, 32'hFFFF_E830);
        handshake();

        // len=0: result 0 next cycle, a waiting word survives for the next job
        $display("[TB] test 3: zero length job");
        pushWord(mkWord(8'd3, 8'hFE));
        startJob(8'd0);
        checkOutput("t3Valid", {31'd0, resultValid}, 32'd1);
        checkOutput("t3Result", resultOut, 32'd0);
        handshake();
        startJob(8'd1);
        waitValid(lat);
        checkOutput("t3Leftover", resultOut, 32'hFFFF_FFA0);
        handshake();

        // Five words into a depth-4 FIFO: the fifth is dropped
        $display("[TB] test 4: overflow");
        pushWord(mkWord(8'd1, 8'd2));
        pushWord(mkWord(8'd2, 8'd3));
        pushWord(mkWord(8'd3, 8'd4));
        checkOutput("t4NotFull", {31'd0, fifoFull}, 32'd0);
        pushWord(mkWord(8'd4, 8'd5));
        checkOutput("t4Full", {31'd0, fifoFull}, 32'd1);
        pushWord(mkWord(8'd5, 8'd6));
        checkOutput("t4Ovf", {31'd0, overflow}, 32'd1);
        startJob(8'd4);
        checkOutput("t4OvfClear", {31'd0, overflow}, 32'd0);
        waitValid(lat);
        checkOutput("t4Result", resultOut, 32'd640);
        handshake();

        // Result held for 10 cycles with start requests that must be ignored
        $display("[TB] test 5: held result");
        pushWord(mkWord(8'd7, 8'd7));
        startJob(8'd1);
        waitValid(lat);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 8'd5, 1'b0);
            checkOutput("t5Hold", resultOut, 32'd784);
            checkOutput("t5HoldValid", {31'd0, resultValid}, 32'd1);
        end
        handshake();
        checkOutput("t5Idle", {31'd0, busy}, 32'd0);
        pushWord(mkWord(8'd2, 8'hFF));
        startJob(8'd1);
        checkOutput("t5Accepted", {31'd0, busy}, 32'd1);
        waitValid(lat);
        checkOutput("t5Result", resultOut, 32'hFFFF_FFE0);
        handshake();

        // Reset in the middle of a three word job
        $display("[TB] test 6: reset mid job");
        startJob(8'd3);
        pushWord(mkWord(8'd9, 8'd9));
        idleCycles(2);
        #2 rstN = 1'b0;
        #1;
        checkOutput("t6Busy", {31'd0, busy}, 32'd0);
        checkOutput("t6Result", resultOut, 32'd0);
        checkOutput("t6Valid", {31'd0, resultValid}, 32'd0);
        @(negedge clkPe);
        @(negedge clkPe);
        #2 rstN = 1'b1;
        @(negedge clkPe);
        pushWord(mkWord(8'h80, 8'h80));
        startJob(8'd1);
        waitValid(lat);
        checkOutput("t6Fresh", resultOut, 32'h0004_0000);
        handshake();
        idleCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
